// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, state/word types, xtime, RotWord
// and the forward S-box table. subBytes uses the same table.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int RND_W  = $clog2(AES_NR + 1);

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } ark_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8); 80 wraps to 1B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Cyclic left rotation of a key word by one byte.
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/add_round_key_sched_if.sv
// Handshake bundle for add_round_key_sched: key load, state input and keyed
// output channels. Optional last-key outputs exist only when
// ADD_ROUND_KEY_SCHED_LAST_KEY_EN is defined.
interface add_round_key_sched_if;
   import aes_pkg::*;

   logic             key_valid;
   logic             key_ready;
   state_t           key_in;
   logic             in_valid;
   logic             in_ready;
   state_t           data_in;
   logic             out_valid;
   logic             out_ready;
   state_t           data_out;
   logic [RND_W-1:0] out_round;
   logic             out_last;
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
   state_t           last_key;
   logic             last_key_valid;
`endif

   // The keying stage itself.
   modport slave (
      input  key_valid, key_in, in_valid, data_in, out_ready,
      output key_ready, in_ready, out_valid, data_out, out_round, out_last
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
      , output last_key, last_key_valid
`endif
   );

   // Upstream/downstream environment driving the stage.
   modport master (
      output key_valid, key_in, in_valid, data_in, out_ready,
      input  key_ready, in_ready, out_valid, data_out, out_round, out_last
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
      , input last_key, last_key_valid
`endif
   );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup, purely combinational.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_a,
   output logic [7:0] o_s
);

   assign o_s = SBOX[i_a];

endmodule

// File: rtl/add_round_key_sched.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule. One state beat
// per round is XORed with the current round key and registered for subBytes;
// the key advances one expansion step per accepted beat.
// Optional: ADD_ROUND_KEY_SCHED_LAST_KEY_EN captures the round-NR key.
module add_round_key_sched
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input logic                 clk,
   input logic                 rst,
   add_round_key_sched_if.slave bus
);

   ark_state_e       r_state;
   logic             r_key_ready;
   logic [RND_W-1:0] r_round;
   logic [7:0]       r_rcon;
   state_t           r_rk;

   logic             r_out_valid;
   state_t           r_data_out;
   logic [RND_W-1:0] r_out_round;
   logic             r_out_last;

`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
   state_t           r_last_key;
   logic             r_last_key_valid;
`endif

   word_t  w_w0, w_w1, w_w2, w_w3;
   word_t  w_rot, w_sub, w_t;
   word_t  w_n0, w_n1, w_n2, w_n3;
   state_t w_rk_next;
   logic   w_in_ready, w_accept, w_consume, w_last_round;

   // Key expansion: t = SubWord(RotWord(w3)) ^ {rcon,0}, then chained XORs.
   assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
   assign w_rot = rot_word(w_w3);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .i_a (w_rot[8*i +: 8]),
         .o_s (w_sub[8*i +: 8])
      );
   end

   assign w_t       = w_sub ^ {r_rcon, 24'h0};
   assign w_n0      = w_w0 ^ w_t;
   assign w_n1      = w_w1 ^ w_n0;
   assign w_n2      = w_w2 ^ w_n1;
   assign w_n3      = w_w3 ^ w_n2;
   assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

   // Single output register: a new beat fits whenever the slot is empty or
   // being drained this cycle.
   assign w_in_ready   = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
   assign w_accept     = bus.in_valid && w_in_ready;
   assign w_consume    = r_out_valid && bus.out_ready;
   assign w_last_round = (r_round == RND_W'(NR));

   // Control FSM and key schedule state: load key in IDLE, step per beat in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_key_ready      <= 1'b1;
         r_round          <= '0;
         r_rcon           <= 8'h01;
         r_rk             <= '0;
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
         r_last_key       <= '0;
         r_last_key_valid <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register here samples the
         // pre-edge values of its neighbours, matching real flip-flops.
         case (r_state)
            ST_IDLE: begin
               if (bus.key_valid) begin
                  r_rk        <= bus.key_in;
                  r_rcon      <= 8'h01;
                  r_round     <= '0;
                  r_key_ready <= 1'b0;
                  r_state     <= ST_RUN;
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
                  r_last_key_valid <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_rk    <= w_rk_next;
                  r_rcon  <= xtime(r_rcon);
                  r_round <= r_round + RND_W'(1);
                  if (w_last_round) begin
                     r_state     <= ST_IDLE;
                     r_key_ready <= 1'b1;
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
                     r_last_key       <= r_rk;
                     r_last_key_valid <= 1'b1;
`endif
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_key_ready <= 1'b1;
            end
         endcase
      end
   end

   // Output register: load keyed state on accept, clear valid on bare consume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_data_out  <= '0;
         r_out_round <= '0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_data_out  <= bus.data_in ^ r_rk;
         r_out_round <= r_round;
         r_out_last  <= w_last_round;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.key_ready = r_key_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data_out;
   assign bus.out_round = r_out_round;
   assign bus.out_last  = r_out_last;
`ifdef ADD_ROUND_KEY_SCHED_LAST_KEY_EN
   assign bus.last_key       = r_last_key;
   assign bus.last_key_valid = r_last_key_valid;
`endif

endmodule

// File: doc/add_round_key_sched.md
Name: add_round_key_sched

Overview:
- Sequential AddRoundKey stage sitting directly upstream of subBytes in the AES-128 encryption datapath.
- Holds an on-the-fly key schedule. Accepts one 128-bit state per round, XORs it with the current round key, and registers the result for subBytes.
- Advances the key by one expansion step per accepted beat, so no 11-key storage is needed.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; the round counter width derives from it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  block can load a new key.
- key_in  in  128  cipher key; w0 = [127:96], MSB byte first.
- in_valid  in  1  state beat offered; round 0 is plaintext, later rounds come from mixColumns/shiftRows.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- data_in  in  128  state to be keyed.
- out_valid  out  1  data_out holds a keyed state.
- out_ready  in  1  downstream consumes.
- data_out  out  128  data_in XOR round key; feeds subBytes text_in.
- out_round  out  4  round index of data_out, 0..NR.
- out_last  out  1  data_out is the final ciphertext (round NR).

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - out_valid=0, data_out=0, out_round=0, out_last=0.
  - FSM=IDLE, round=0, rcon=8'h01, round-key register=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - key_ready=1, in_ready=0.
  - On key_valid: rk<=key_in, rcon<=01, round<=0, go to RUN.
- RUN:
  - key_ready=0; key_valid is ignored.
  - in_ready = !out_valid | out_ready (single output register with pass-through on consume).
- On accept in RUN:
  - data_out<=data_in^rk; out_round<=round; out_last<=(round==NR); out_valid<=1.
  - rk<=expand(rk,rcon); rcon<=xtime(rcon); round<=round+1.
- On accepting round NR: go to IDLE next cycle. The out register still holds the last beat until consumed. A new key may load in the same cycle the last beat is drained.
- Output handshake: out_valid falls on out_ready with no new accept. Accept and consume in the same cycle keep out_valid=1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- expand:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime wraps 80 to 1B.
- data_out, out_round and out_last are stable while out_valid & !out_ready.
- Upstream must not drop in_valid once asserted until accepted.

Optional Feature:
- Macro: ADD_ROUND_KEY_SCHED_LAST_KEY_EN.
- When defined:
  - Adds output last_key[127:0] and output last_key_valid.
  - On accepting round NR, last_key<=rk (round-10 key) and last_key_valid<=1. This seeds a future inverse cipher.
  - last_key_valid clears on key load; both reset to 0.
- When undefined: ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR=10.
  - Typedefs for state_t (128-bit) and word_t (32-bit).
  - Functions xtime, rot_word and the S-box table constant. The same table is used by subBytes.
- One sub-module, aes_sbox: 8-bit combinational lookup, instantiated 4x for SubWord.

Test Plan:
- Reset then load key 2b7e151628aed2a6abf7158809cf4f3c; send data_in 3243f6a8885a308d313198a2e0370734 -> data_out 193de3bea0f4e22b9ac68d2ae9f84808, out_round 0, 1 cycle later.
- Same key; round 0 beat, then round 1 beat with data_in=0 -> data_out a0fafe1788542cb123a339392a6c7605, out_round 1.
- Same key; 11 beats of zeros back-to-back with out_ready=1:
  - Final data_out is d014f9a8c9ee2589e13f0cc8b6630ca6, with out_last=1 and out_round 10.
  - key_ready=1 the cycle after.
- Hold out_ready=0 for 3 cycles after first beat -> in_ready=0, data_out is stable, rk does not advance; release -> next beat is keyed with the round 1 key.
- Assert rst after round 5 is accepted -> all outputs 0 and key_ready=1 immediately. Reload the same key -> round 0 output matches the first scenario.
- With the macro defined, run the third scenario -> last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and last_key_valid=1; next key load clears last_key_valid.
